blit_engine: RTL and testbench
==============================

Name: blit_engine

Overview:
- Parametrised rectangle blitter, next generation of the sprite copy engine; sits between sprite/texture ROMs and the SRAM frame-buffer programming port.
- Copies a W×H sub-rectangle of a strided source image to screen coordinates.
- Adds optional horizontal flip, a transparency key, screen clipping and a valid/ready back-pressure handshake to the SRAM controller.
- Start/abort/busy/done control replaces the level-held execute.

Parameters:
SrcAddrWidth, 16, source address width (bits)
DataWidth, 16, pixel width (bits)
CoordWidth, 10, screen coordinate width
ScreenW, 640, clip limit on x (exclusive)
ScreenH, 480, clip limit on y (exclusive)
TransparentColor, 16'h07E0, colour key never written (DataWidth bits)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
dest_x_start  in  CoordWidth  first dest column
dest_x_end  in  CoordWidth  dest column end, exclusive
dest_y_start  in  CoordWidth  first dest row
dest_y_end  in  CoordWidth  dest row end, exclusive
src_addr_start  in  SrcAddrWidth  address of source pixel (0,0)
src_stride  in  SrcAddrWidth  source words per row
hflip  in  1  mirror each row horizontally
start  in  1  single-cycle pulse, sampled only in IDLE
abort  in  1  cancel the current job
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse on normal completion
src_addr  out  SrcAddrWidth  source read address
src_data  in  DataWidth  data for the previous cycle's src_addr (1-cycle synchronous ROM)
program_x  out  CoordWidth  write x
program_y  out  CoordWidth  write y
program_data  out  DataWidth  write pixel
program_write  out  1  write valid
program_ready  in  1  SRAM controller accepts the write

Behaviour:
- Reset (reset_n low, asynchronous):
  - State IDLE.
  - busy=0, done=0, program_write=0.
  - program_x/y/data=0; all internal counters and valids cleared.
- States and transitions:
  - IDLE → RUN on start=1, latching all control inputs. Empty rect (x_end<=x_start or y_end<=y_start) goes IDLE → DONE instead.
  - RUN → DRAIN once the last pixel's address is issued.
  - DRAIN → DONE once the output register is empty or its write is accepted.
  - DONE → IDLE unconditionally; done=1 only in DONE.
- Control inputs are latched at start; changes during a job have no effect.
- Addressing:
  - Pixel (c,r), with w=x_end-x_start, has address src_addr_start + r*src_stride + (hflip ? w-1-c : c).
  - Implemented incrementally with a row-base register (+src_stride per row).
  - Arithmetic is modulo 2^SrcAddrWidth; no multiplier.
- Pipeline:
  - Stage A holds the pixel whose address was issued last cycle.
  - Output register holds the write.
  - adv = !program_write || program_ready.
  - src_addr = adv ? next pixel address : stage-A address, so the ROM re-presents the same data during a stall.
  - In IDLE, src_addr = src_addr_start.
- Write rule: on adv, stage A moves to the output register with valid = stageA_valid && src_data!=TransparentColor && x<ScreenW && y<ScreenH. Dropped pixels consume no cycles beyond their slot.
- Handshake: program_x/y/data/write hold stable while program_write=1 and program_ready=0. A transfer occurs on a cycle with both high.
- Latency: start sampled at edge 0 → first program_write high in the cycle after edge 2. Throughput is one pixel/cycle when program_ready=1.
- Coordinates wrap modulo 2^CoordWidth. Wrapped values ≥ ScreenW/ScreenH are clipped; smaller wrapped values are written.
- abort=1 in RUN/DRAIN:
  - Next state IDLE; stage A and output valid cleared; no done.
  - A pending unaccepted write is discarded.
  - abort in IDLE/DONE is ignored; abort and start together in IDLE means abort wins (stay IDLE).
- start while busy is ignored.

Optional Feature:
BLIT_FILL_EN
- Defined:
  - Adds inputs fill_mode (1) and fill_color (DataWidth), latched at start.
  - When fill_mode=1, program_data = fill_color and the colour key is not applied; clipping still applies. src_addr still sequences but src_data is ignored.
- Undefined: ports absent, pure blit behaviour.

Test Plan:
- 4×2 blit at (10,20), src_addr_start=100, stride=8, ready=1 → 8 writes on consecutive cycles, addrs 100–103,108–111, x 10–13, y 20–21; done pulses once, 1 cycle after the last write.
- Same job with hflip=1 → data order per row from addrs 103,102,101,100 then 111..108.
- Source pixel 2 = 16'h07E0, plus a rect spanning x 638–641 → no write for pixel 2 or for x≥640; remaining writes correct.
- program_ready toggled 0/1 every other cycle → outputs stable during stalls, no pixel lost or duplicated, done after all 8 accepted.
- abort asserted mid-RUN with a write stalled → program_write low next cycle, busy=0, no done; a new start then runs cleanly.
- Empty rect (x_end==x_start) → zero writes, done one cycle after start; with BLIT_FILL_EN, fill_mode=1 and fill_color=16'hF800 on 2×2 → four writes of F800.

Source files
------------

// File: rtl/blit_engine.sv
// blit_engine: strided rectangle blitter with hflip, colour key, screen clipping and write back-pressure.
// Define BLIT_FILL_EN to add a solid-colour fill mode (fill_mode/fill_color ports).
module blit_engine #(
  parameter int SrcAddrWidth = 16,
  parameter int DataWidth = 16,
  parameter int CoordWidth = 10,
  parameter int ScreenW = 640,
  parameter int ScreenH = 480,
  parameter logic [DataWidth-1:0] TransparentColor = 16'h07E0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CoordWidth-1:0]   dest_x_start,
  input  logic [CoordWidth-1:0]   dest_x_end,
  input  logic [CoordWidth-1:0]   dest_y_start,
  input  logic [CoordWidth-1:0]   dest_y_end,
  input  logic [SrcAddrWidth-1:0] src_addr_start,
  input  logic [SrcAddrWidth-1:0] src_stride,
  input  logic                    hflip,
`ifdef BLIT_FILL_EN
  input  logic                    fill_mode,
  input  logic [DataWidth-1:0]    fill_color,
`endif
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [SrcAddrWidth-1:0] src_addr,
  input  logic [DataWidth-1:0]    src_data,
  output logic [CoordWidth-1:0]   program_x,
  output logic [CoordWidth-1:0]   program_y,
  output logic [DataWidth-1:0]    program_data,
  output logic                    program_write,
  input  logic                    program_ready
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CoordWidth-1:0] x0_q, x0_d, x1_q, x1_d, y1_q, y1_d, cx_q, cx_d, cy_q, cy_d;
  logic [SrcAddrWidth-1:0] base_q, base_d, addr_q, addr_d, stride_q, stride_d, wm1_q, wm1_d;
  logic hflip_q, hflip_d;
  logic a_valid_q, a_valid_d, o_valid_q, o_valid_d;
  logic [CoordWidth-1:0] a_x_q, a_x_d, a_y_q, a_y_d, o_x_q, o_x_d, o_y_q, o_y_d;
  logic [SrcAddrWidth-1:0] a_addr_q, a_addr_d, start_wm1;
  logic [DataWidth-1:0] o_data_q, o_data_d, pix;
  logic adv, launch, issue, job_active, last_col, last_row, key_ok, in_screen;

  assign adv        = !o_valid_q || program_ready;
  assign launch     = state_q == IDLE && start && !abort;
  assign job_active = state_q == RUN || state_q == DRAIN;
  assign issue      = state_q == RUN && adv && !abort;
  assign last_col   = cx_q == x1_q - CoordWidth'(1);
  assign last_row   = cy_q == y1_q - CoordWidth'(1);
  assign start_wm1  = SrcAddrWidth'(dest_x_end - dest_x_start - CoordWidth'(1));
  assign in_screen  = 32'(a_x_q) < 32'(ScreenW) && 32'(a_y_q) < 32'(ScreenH);

`ifdef BLIT_FILL_EN
  logic fill_q;
  logic [DataWidth-1:0] fcol_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      fill_q <= 1'b0;
      fcol_q <= '0;
    end else if (launch) begin
      fill_q <= fill_mode;
      fcol_q <= fill_color;
    end
  assign pix    = fill_q ? fcol_q : src_data;
  assign key_ok = fill_q || src_data != TransparentColor;
`else
  assign pix    = src_data;
  assign key_ok = src_data != TransparentColor;
`endif

  always_comb begin
    state_d = state_q;
    x0_d = x0_q; x1_d = x1_q; y1_d = y1_q; cx_d = cx_q; cy_d = cy_q;
    base_d = base_q; addr_d = addr_q; stride_d = stride_q; wm1_d = wm1_q; hflip_d = hflip_q;
    a_valid_d = a_valid_q; a_x_d = a_x_q; a_y_d = a_y_q; a_addr_d = a_addr_q;
    o_valid_d = o_valid_q; o_x_d = o_x_q; o_y_d = o_y_q; o_data_d = o_data_q;
    case (state_q)
      IDLE:    if (launch) state_d = (dest_x_end <= dest_x_start || dest_y_end <= dest_y_start) ? DONE : RUN;
      RUN:     if (issue && last_col && last_row) state_d = DRAIN;
      DRAIN:   if (!a_valid_q && adv) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (launch) begin
      x0_d = dest_x_start; x1_d = dest_x_end; y1_d = dest_y_end;
      cx_d = dest_x_start; cy_d = dest_y_start;
      base_d = src_addr_start; stride_d = src_stride; hflip_d = hflip; wm1_d = start_wm1;
      addr_d = src_addr_start + (hflip ? start_wm1 : '0);
    end
    // addresses walk incrementally; a row wrap rebases on the next source row
    if (issue) begin
      cx_d = last_col ? x0_q : cx_q + CoordWidth'(1);
      cy_d = last_col ? cy_q + CoordWidth'(1) : cy_q;
      base_d = last_col ? base_q + stride_q : base_q;
      addr_d = last_col ? base_q + stride_q + (hflip_q ? wm1_q : '0)
             : hflip_q ? addr_q - SrcAddrWidth'(1) : addr_q + SrcAddrWidth'(1);
    end
    if (adv) begin
      a_valid_d = issue; a_x_d = cx_q; a_y_d = cy_q; a_addr_d = addr_q;
      o_valid_d = a_valid_q && key_ok && in_screen;
      o_x_d = a_x_q; o_y_d = a_y_q; o_data_d = pix;
    end
    if (abort && job_active) begin
      state_d = IDLE;
      a_valid_d = 1'b0;
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      x0_q <= '0; x1_q <= '0; y1_q <= '0; cx_q <= '0; cy_q <= '0;
      base_q <= '0; addr_q <= '0; stride_q <= '0; wm1_q <= '0; hflip_q <= 1'b0;
      a_valid_q <= 1'b0; a_x_q <= '0; a_y_q <= '0; a_addr_q <= '0;
      o_valid_q <= 1'b0; o_x_q <= '0; o_y_q <= '0; o_data_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q <= x0_d; x1_q <= x1_d; y1_q <= y1_d; cx_q <= cx_d; cy_q <= cy_d;
      base_q <= base_d; addr_q <= addr_d; stride_q <= stride_d; wm1_q <= wm1_d; hflip_q <= hflip_d;
      a_valid_q <= a_valid_d; a_x_q <= a_x_d; a_y_q <= a_y_d; a_addr_q <= a_addr_d;
      o_valid_q <= o_valid_d; o_x_q <= o_x_d; o_y_q <= o_y_d; o_data_q <= o_data_d;
    end

  // during a stall the stage-A address is re-presented so its ROM data stays valid
  assign src_addr      = state_q == IDLE ? src_addr_start : adv ? addr_q : a_addr_q;
  assign busy          = job_active;
  assign done          = state_q == DONE;
  assign program_x     = o_x_q;
  assign program_y     = o_y_q;
  assign program_data  = o_data_q;
  assign program_write = o_valid_q;
endmodule

// File: tb/tb_blit_engine.sv
// tb_blit_engine: directed self-checking bench for blit_engine.
// Define BLIT_FILL_EN to also exercise the fill mode.
`timescale 1ns/1ps
module tb_blit_engine;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [9:0] dest_x_start, dest_x_end, dest_y_start, dest_y_end, program_x, program_y;
  logic [15:0] src_addr_start, src_stride, src_addr, src_data, program_data;
  logic hflip, start, abort, busy, done, program_write, program_ready;
`ifdef BLIT_FILL_EN
  logic fill_mode;
  logic [15:0] fill_color;
`endif
  logic [15:0] rom [256];
  int cyc = 0, total = 0, bad = 0, done_cnt = 0, done_cyc = 0, stall_err = 0, start_cyc = 0;
  int wx[$], wy[$], wd[$], wc[$];
  logic p_pend = 1'b0;
  logic [9:0] p_x, p_y;
  logic [15:0] p_d;

  blit_engine dut (
    .clk(clk), .reset_n(reset_n),
    .dest_x_start(dest_x_start), .dest_x_end(dest_x_end),
    .dest_y_start(dest_y_start), .dest_y_end(dest_y_end),
    .src_addr_start(src_addr_start), .src_stride(src_stride), .hflip(hflip),
`ifdef BLIT_FILL_EN
    .fill_mode(fill_mode), .fill_color(fill_color),
`endif
    .start(start), .abort(abort), .busy(busy), .done(done),
    .src_addr(src_addr), .src_data(src_data),
    .program_x(program_x), .program_y(program_y), .program_data(program_data),
    .program_write(program_write), .program_ready(program_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) src_data <= rom[src_addr[7:0]];

  always @(negedge clk)
    if (reset_n) begin
      if (program_write && program_ready) begin
        wx.push_back(int'(program_x));
        wy.push_back(int'(program_y));
        wd.push_back(int'(program_data));
        wc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (p_pend && (program_write !== 1'b1 || program_x !== p_x || program_y !== p_y || program_data !== p_d))
        stall_err++;
      p_pend = program_write && !program_ready && !abort;
      p_x = program_x; p_y = program_y; p_d = program_data;
    end else p_pend = 1'b0;

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic launch(input logic [9:0] xs, xe, ys, ye, input logic [15:0] sa, st, input logic hf);
    dest_x_start = xs; dest_x_end = xe; dest_y_start = ys; dest_y_end = ye;
    src_addr_start = sa; src_stride = st; hflip = hf; start = 1'b1;
    idle(1);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic test_reset;
    idle(2);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (program_write !== 1'b0) begin bad++; $display("FAIL reset_write got=%b want=0", program_write); end
    total++; if (program_x !== 10'd0 || program_y !== 10'd0) begin bad++; $display("FAIL reset_xy got=%0d,%0d want=0,0", program_x, program_y); end
    total++; if (program_data !== 16'd0) begin bad++; $display("FAIL reset_data got=%h want=0000", program_data); end
    total++; if (src_addr !== 16'h0123) begin bad++; $display("FAIL reset_src_addr got=%h want=0123", src_addr); end
    reset_n = 1'b1;
    idle(1);
    launch(10, 14, 20, 22, 16'd100, 16'd8, 1'b0);
    idle(3);
    #2 reset_n = 1'b0;
    #1;
    total++; if (program_write !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL async_reset got write=%b busy=%b want 0 0", program_write, busy); end
    @(posedge clk); #1 reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic;
    int wb, db;
    wb = wx.size(); db = done_cnt;
    launch(10, 14, 20, 22, 16'd100, 16'd8, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
    total++; if (src_addr !== 16'd100) begin bad++; $display("FAIL basic_first_addr got=%0d want=100", src_addr); end
    dest_x_start = 10'd500; src_addr_start = 16'd0; src_stride = 16'd3; hflip = 1'b1; start = 1'b1;
    idle(1);
    start = 1'b0;
    idle(20);
    total++; if (wx.size() - wb != 8) begin bad++; $display("FAIL basic_count got=%0d want=8", wx.size() - wb); end
    for (int i = 0; i < 8; i++) begin
      int a;
      a = 100 + (i / 4) * 8 + i % 4;
      total++;
      if (qget(wx, wb+i) != 10 + i % 4 || qget(wy, wb+i) != 20 + i / 4 || qget(wd, wb+i) != 'hA000 + a || qget(wc, wb+i) != start_cyc + 2 + i) begin
        bad++;
        $display("FAIL basic_px%0d got x=%0d y=%0d d=%h cyc=%0d want x=%0d y=%0d d=%h cyc=%0d", i,
          qget(wx, wb+i), qget(wy, wb+i), qget(wd, wb+i), qget(wc, wb+i), 10 + i % 4, 20 + i / 4, 'hA000 + a, start_cyc + 2 + i);
      end
    end
    total++; if (done_cnt - db != 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", done_cnt - db); end
    total++; if (done_cyc != start_cyc + 10) begin bad++; $display("FAIL basic_done_cycle got=%0d want=%0d", done_cyc, start_cyc + 10); end
  endtask

  task automatic test_hflip;
    int wb, db;
    wb = wx.size(); db = done_cnt;
    launch(10, 14, 20, 22, 16'd100, 16'd8, 1'b1);
    total++; if (src_addr !== 16'd103) begin bad++; $display("FAIL hflip_first_addr got=%0d want=103", src_addr); end
    idle(20);
    total++; if (wx.size() - wb != 8) begin bad++; $display("FAIL hflip_count got=%0d want=8", wx.size() - wb); end
    for (int i = 0; i < 8; i++) begin
      int a;
      a = 100 + (i / 4) * 8 + 3 - i % 4;
      total++;
      if (qget(wx, wb+i) != 10 + i % 4 || qget(wy, wb+i) != 20 + i / 4 || qget(wd, wb+i) != 'hA000 + a) begin
        bad++;
        $display("FAIL hflip_px%0d got x=%0d y=%0d d=%h want x=%0d y=%0d d=%h", i,
          qget(wx, wb+i), qget(wy, wb+i), qget(wd, wb+i), 10 + i % 4, 20 + i / 4, 'hA000 + a);
      end
    end
    total++; if (done_cnt - db != 1) begin bad++; $display("FAIL hflip_done_count got=%0d want=1", done_cnt - db); end
  endtask

  task automatic test_key_clip;
    int wb, db;
    int ex[3] = '{638, 639, 638};
    int ey[3] = '{5, 5, 6};
    int ed[3] = '{'hA064, 'hA065, 'hA06C};
    int ec[3] = '{2, 3, 6};
    rom[102] = 16'h07E0;
    rom[109] = 16'h07E0;
    wb = wx.size(); db = done_cnt;
    launch(638, 642, 5, 7, 16'd100, 16'd8, 1'b0);
    idle(20);
    total++; if (wx.size() - wb != 3) begin bad++; $display("FAIL keyclip_count got=%0d want=3", wx.size() - wb); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (qget(wx, wb+i) != ex[i] || qget(wy, wb+i) != ey[i] || qget(wd, wb+i) != ed[i] || qget(wc, wb+i) != start_cyc + ec[i]) begin
        bad++;
        $display("FAIL keyclip_px%0d got x=%0d y=%0d d=%h cyc=%0d want x=%0d y=%0d d=%h cyc=%0d", i,
          qget(wx, wb+i), qget(wy, wb+i), qget(wd, wb+i), qget(wc, wb+i), ex[i], ey[i], ed[i], start_cyc + ec[i]);
      end
    end
    total++; if (done_cyc != start_cyc + 10 || done_cnt - db != 1) begin bad++; $display("FAIL keyclip_done got cyc=%0d n=%0d want cyc=%0d n=1", done_cyc, done_cnt - db, start_cyc + 10); end
    wb = wx.size();
    launch(3, 5, 479, 481, 16'd100, 16'd8, 1'b0);
    idle(12);
    total++; if (wx.size() - wb != 2) begin bad++; $display("FAIL yclip_count got=%0d want=2", wx.size() - wb); end
    total++;
    if (qget(wx, wb) != 3 || qget(wy, wb) != 479 || qget(wd, wb) != 'hA064 || qget(wx, wb+1) != 4 || qget(wy, wb+1) != 479 || qget(wd, wb+1) != 'hA065) begin
      bad++;
      $display("FAIL yclip_px got (%0d,%0d,%h)(%0d,%0d,%h) want (3,479,a064)(4,479,a065)",
        qget(wx, wb), qget(wy, wb), qget(wd, wb), qget(wx, wb+1), qget(wy, wb+1), qget(wd, wb+1));
    end
    rom[102] = 16'hA066;
    rom[109] = 16'hA06D;
  endtask

  task automatic test_stall;
    int wb, db, sb, lastc;
    wb = wx.size(); db = done_cnt; sb = stall_err;
    launch(10, 14, 20, 22, 16'd100, 16'd8, 1'b0);
    repeat (40) begin
      program_ready = ~program_ready;
      idle(1);
    end
    program_ready = 1'b1;
    idle(2);
    total++; if (wx.size() - wb != 8) begin bad++; $display("FAIL stall_count got=%0d want=8", wx.size() - wb); end
    for (int i = 0; i < 8; i++) begin
      int a;
      a = 100 + (i / 4) * 8 + i % 4;
      total++;
      if (qget(wx, wb+i) != 10 + i % 4 || qget(wy, wb+i) != 20 + i / 4 || qget(wd, wb+i) != 'hA000 + a) begin
        bad++;
        $display("FAIL stall_px%0d got x=%0d y=%0d d=%h want x=%0d y=%0d d=%h", i,
          qget(wx, wb+i), qget(wy, wb+i), qget(wd, wb+i), 10 + i % 4, 20 + i / 4, 'hA000 + a);
      end
    end
    total++; if (stall_err != sb) begin bad++; $display("FAIL stall_hold got=%0d unstable cycles want=0", stall_err - sb); end
    lastc = qget(wc, wb + 7);
    total++; if (done_cnt - db != 1 || done_cyc != lastc + 1) begin bad++; $display("FAIL stall_done got cyc=%0d n=%0d want cyc=%0d n=1", done_cyc, done_cnt - db, lastc + 1); end
  endtask

  task automatic test_abort;
    int wb, db;
    program_ready = 1'b0;
    wb = wx.size(); db = done_cnt;
    launch(10, 14, 20, 22, 16'd100, 16'd8, 1'b0);
    idle(3);
    total++; if (program_write !== 1'b1) begin bad++; $display("FAIL abort_pre_write got=%b want=1", program_write); end
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    total++; if (program_write !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_stop got write=%b busy=%b want 0 0", program_write, busy); end
    idle(10);
    total++; if (done_cnt != db) begin bad++; $display("FAIL abort_no_done got=%0d want=0", done_cnt - db); end
    program_ready = 1'b1;
    wb = wx.size(); db = done_cnt;
    launch(10, 14, 20, 22, 16'd100, 16'd8, 1'b0);
    idle(20);
    total++; if (wx.size() - wb != 8) begin bad++; $display("FAIL abort_rerun_count got=%0d want=8", wx.size() - wb); end
    for (int i = 0; i < 8; i++) begin
      int a;
      a = 100 + (i / 4) * 8 + i % 4;
      total++;
      if (qget(wx, wb+i) != 10 + i % 4 || qget(wy, wb+i) != 20 + i / 4 || qget(wd, wb+i) != 'hA000 + a) begin
        bad++;
        $display("FAIL abort_rerun_px%0d got x=%0d y=%0d d=%h want x=%0d y=%0d d=%h", i,
          qget(wx, wb+i), qget(wy, wb+i), qget(wd, wb+i), 10 + i % 4, 20 + i / 4, 'hA000 + a);
      end
    end
    total++; if (done_cnt - db != 1) begin bad++; $display("FAIL abort_rerun_done got=%0d want=1", done_cnt - db); end
  endtask

  task automatic test_abort_start;
    int db;
    db = done_cnt;
    start = 1'b1; abort = 1'b1;
    idle(1);
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_start_busy got=%b want=0", busy); end
    idle(4);
    total++; if (done_cnt != db) begin bad++; $display("FAIL abort_start_done got=%0d want=0", done_cnt - db); end
  endtask

  task automatic test_empty;
    int wb, db;
    wb = wx.size(); db = done_cnt;
    launch(50, 50, 0, 4, 16'd100, 16'd8, 1'b0);
    total++; if (busy !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL empty_x_state got busy=%b done=%b want 0 1", busy, done); end
    idle(5);
    total++; if (wx.size() != wb || done_cnt - db != 1 || done_cyc != start_cyc) begin bad++; $display("FAIL empty_x got writes=%0d dones=%0d cyc=%0d want 0 1 %0d", wx.size() - wb, done_cnt - db, done_cyc, start_cyc); end
    db = done_cnt;
    launch(0, 4, 7, 3, 16'd100, 16'd8, 1'b0);
    idle(5);
    total++; if (wx.size() != wb || done_cnt - db != 1 || done_cyc != start_cyc) begin bad++; $display("FAIL empty_y got writes=%0d dones=%0d cyc=%0d want 0 1 %0d", wx.size() - wb, done_cnt - db, done_cyc, start_cyc); end
  endtask

`ifdef BLIT_FILL_EN
  task automatic test_fill;
    int wb;
    rom[100] = 16'h07E0;
    wb = wx.size();
    fill_mode = 1'b1; fill_color = 16'hF800;
    launch(10, 12, 20, 22, 16'd100, 16'd8, 1'b0);
    fill_mode = 1'b0; fill_color = 16'h0000;
    idle(15);
    total++; if (wx.size() - wb != 4) begin bad++; $display("FAIL fill_count got=%0d want=4", wx.size() - wb); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (qget(wx, wb+i) != 10 + i % 2 || qget(wy, wb+i) != 20 + i / 2 || qget(wd, wb+i) != 'hF800) begin
        bad++;
        $display("FAIL fill_px%0d got x=%0d y=%0d d=%h want x=%0d y=%0d d=f800", i,
          qget(wx, wb+i), qget(wy, wb+i), qget(wd, wb+i), 10 + i % 2, 20 + i / 2);
      end
    end
    rom[100] = 16'hA064;
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hA000 + 16'(i);
    dest_x_start = '0; dest_x_end = '0; dest_y_start = '0; dest_y_end = '0;
    src_addr_start = 16'h0123; src_stride = '0; hflip = 1'b0;
    start = 1'b0; abort = 1'b0; program_ready = 1'b1;
`ifdef BLIT_FILL_EN
    fill_mode = 1'b0; fill_color = '0;
`endif
    test_reset;
    test_basic;
    test_hflip;
    test_key_clip;
    test_stall;
    test_abort;
    test_abort_start;
    test_empty;
`ifdef BLIT_FILL_EN
    test_fill;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
